// File: rtl/hilo_register_unit.sv
// HI/LO register unit for the memory stage: commits multiply/divide/MTHI/MTLO results and serves MFHI/MFLO.
// Optional macro HILO_STALL_COUNTER_EN enables the divide stall-cycle counter on stall_cycles.
module hilo_register_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        multiply_valid,
  input  logic [63:0] multiply_result,
  input  logic        divide_valid,
  input  logic        divide_result_valid,
  input  logic [31:0] divide_result,
  input  logic [31:0] divide_remain,
  input  logic [31:0] source_register_data,
  input  logic        result_high,
  input  logic        result_low,
  input  logic        high_low_write,
  input  logic        divider_done,
  input  logic [31:0] divider_quotient,
  input  logic [31:0] divider_remainder,
  input  logic        flush,
  output logic        read_valid,
  output logic [31:0] read_data,
  output logic [31:0] hi_value,
  output logic [31:0] lo_value,
  output logic [31:0] stall_cycles
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_DIVIDE = 2'd1,
    DRAIN       = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   hi_p1;
  logic [DATA_W-1:0]   lo_p1;
  logic                accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & ~flush;
  assign hi_value = hi_p1;
  assign lo_value = lo_p1;

  // Accept/commit stage: HI/LO and read data registered on the accept or done edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hi_p1      <= '0;
      lo_p1      <= '0;
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      read_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (high_low_write) begin
              if (multiply_valid) begin
                hi_p1 <= multiply_result[63:32];
                lo_p1 <= multiply_result[31:0];
              end else if (divide_valid) begin
                if (divide_result_valid) begin
                  lo_p1 <= divide_result;
                  hi_p1 <= divide_remain;
                end else begin
                  state <= WAIT_DIVIDE;
                end
              end else begin
                if (result_high) hi_p1 <= source_register_data;
                if (result_low)  lo_p1 <= source_register_data;
              end
            end else if (result_high | result_low) begin
              // Reads see the registers as of the accept cycle, so a write one entry earlier is already visible
              read_valid <= 1'b1;
              read_data  <= result_high ? hi_p1 : lo_p1;
            end
          end
        end
        WAIT_DIVIDE: begin
          if (flush) begin
            // A cancelled divide may still complete later; DRAIN swallows that stray done pulse
            state <= divider_done ? IDLE : DRAIN;
          end else if (divider_done) begin
            lo_p1 <= divider_quotient;
            hi_p1 <= divider_remainder;
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (divider_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HILO_STALL_COUNTER_EN
  logic [DATA_W-1:0] stall_cnt_p1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_p1 <= '0;
    end else if (state != IDLE) begin
      stall_cnt_p1 <= stall_cnt_p1 + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_p1;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hilo_register_unit.sv
// Self-checking bench for hilo_register_unit: vector table, directed divide/flush/reset sequences, randomized model check.
module tb_hilo_register_unit;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        multiply_valid;
  logic [63:0] multiply_result;
  logic        divide_valid;
  logic        divide_result_valid;
  logic [31:0] divide_result;
  logic [31:0] divide_remain;
  logic [31:0] source_register_data;
  logic        result_high;
  logic        result_low;
  logic        high_low_write;
  logic        divider_done;
  logic [31:0] divider_quotient;
  logic [31:0] divider_remainder;
  logic        flush;
  logic        read_valid;
  logic [31:0] read_data;
  logic [31:0] hi_value;
  logic [31:0] lo_value;
  logic [31:0] stall_cycles;

  hilo_register_unit dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .multiply_valid(multiply_valid), .multiply_result(multiply_result),
    .divide_valid(divide_valid), .divide_result_valid(divide_result_valid),
    .divide_result(divide_result), .divide_remain(divide_remain),
    .source_register_data(source_register_data), .result_high(result_high),
    .result_low(result_low), .high_low_write(high_low_write),
    .divider_done(divider_done), .divider_quotient(divider_quotient),
    .divider_remainder(divider_remainder), .flush(flush),
    .read_valid(read_valid), .read_data(read_data), .hi_value(hi_value),
    .lo_value(lo_value), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv, mul, dv, drv, hw, rh, rl, fl, done;
    logic [63:0] prod;
    logic [31:0] dq, dr, src;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic iv, mul, dv, drv, hw, rh, rl, fl, done,
                              input logic [63:0] prod, input logic [31:0] dq, dr, src,
                              input logic [31:0] eh, el, input logic erv, input logic [31:0] erd);
    vec_t v;
    v.iv = iv; v.mul = mul; v.dv = dv; v.drv = drv; v.hw = hw; v.rh = rh; v.rl = rl;
    v.fl = fl; v.done = done; v.prod = prod; v.dq = dq; v.dr = dr; v.src = src;
    v.exp_hi = eh; v.exp_lo = el; v.exp_rv = erv; v.exp_rd = erd;
    return v;
  endfunction

  function automatic logic [31:0] stall_exp(input logic [31:0] n);
`ifdef HILO_STALL_COUNTER_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; multiply_valid = 0; multiply_result = '0; divide_valid = 0;
    divide_result_valid = 0; divide_result = '0; divide_remain = '0;
    source_register_data = '0; result_high = 0; result_low = 0; high_low_write = 0;
    divider_done = 0; divider_quotient = '0; divider_remainder = '0; flush = 0;
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.iv; multiply_valid = v.mul; multiply_result = v.prod; divide_valid = v.dv;
    divide_result_valid = v.drv; divide_result = v.dq; divide_remain = v.dr;
    source_register_data = v.src; result_high = v.rh; result_low = v.rl;
    high_low_write = v.hw; divider_done = v.done; divider_quotient = v.dq;
    divider_remainder = v.dr; flush = v.fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  task automatic start_div();
    idle_inputs();
    in_valid = 1; divide_valid = 1; high_low_write = 1;
    step();
    idle_inputs();
  endtask

  // Reference model state
  logic [31:0] m_hi, m_lo, m_rd, m_stall;
  logic        m_rv;
  int          m_mode; // 0 free, 1 awaiting divider, 2 discarding a cancelled divide

  task automatic model_clock();
    logic was_busy;
    was_busy = (m_mode != 0);
    m_rv = 0;
    if (m_mode == 0) begin
      if (in_valid && !flush) begin
        if (high_low_write && multiply_valid) begin
          m_hi = multiply_result[63:32]; m_lo = multiply_result[31:0];
        end else if (high_low_write && divide_valid) begin
          if (divide_result_valid) begin m_lo = divide_result; m_hi = divide_remain; end
          else m_mode = 1;
        end else if (high_low_write) begin
          if (result_high) m_hi = source_register_data;
          if (result_low)  m_lo = source_register_data;
        end else if (result_high || result_low) begin
          m_rv = 1;
          m_rd = result_high ? m_hi : m_lo;
        end
      end
    end else if (m_mode == 1) begin
      if (flush) m_mode = divider_done ? 0 : 2;
      else if (divider_done) begin m_lo = divider_quotient; m_hi = divider_remainder; m_mode = 0; end
    end else begin
      if (divider_done) m_mode = 0;
    end
    if (was_busy) m_stall = m_stall + 1;
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();

    vecs[0]  = mk(1,1,0,0,1,0,0,0,0, 64'h00000001_FFFFFFFE, 0, 0, 0, 32'h1, 32'hFFFFFFFE, 0, 0);
    vecs[1]  = mk(1,0,0,0,0,1,0,0,0, 0, 0, 0, 0, 32'h1, 32'hFFFFFFFE, 1, 32'h1);
    vecs[2]  = mk(1,0,0,0,1,0,1,0,0, 0, 0, 0, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF, 0, 32'h1);
    vecs[3]  = mk(1,0,0,0,0,0,1,0,0, 0, 0, 0, 0, 32'h1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[4]  = mk(1,0,1,1,1,0,0,0,0, 0, 32'h11, 32'h22, 0, 32'h22, 32'h11, 0, 32'hDEADBEEF);
    vecs[5]  = mk(1,0,0,0,1,1,0,1,0, 0, 0, 0, 32'h55, 32'h22, 32'h11, 0, 32'hDEADBEEF);
    vecs[6]  = mk(0,0,0,0,1,1,0,0,0, 0, 0, 0, 32'h66, 32'h22, 32'h11, 0, 32'hDEADBEEF);
    vecs[7]  = mk(1,0,0,0,1,1,0,0,0, 0, 0, 0, 32'h55, 32'h55, 32'h11, 0, 32'hDEADBEEF);
    vecs[8]  = mk(1,0,0,0,0,0,0,0,0, 0, 0, 0, 32'h99, 32'h55, 32'h11, 0, 32'hDEADBEEF);
    vecs[9]  = mk(1,0,0,0,0,1,1,0,0, 0, 0, 0, 0, 32'h55, 32'h11, 1, 32'h55);
    vecs[10] = mk(1,0,0,0,1,1,1,0,0, 0, 0, 0, 32'h77, 32'h77, 32'h77, 0, 32'h55);
    vecs[11] = mk(1,1,0,0,1,0,0,0,0, 64'hFFFFFFFF_00000000, 0, 0, 0, 32'hFFFFFFFF, 32'h0, 0, 32'h55);
    vecs[12] = mk(0,0,0,0,0,0,0,0,1, 0, 32'h1, 32'h2, 0, 32'hFFFFFFFF, 32'h0, 0, 32'h55);

    do_reset();
    chk("reset_hi", hi_value, 0);
    chk("reset_lo", lo_value, 0);
    chk("reset_rv", {31'd0, read_valid}, 0);
    chk("reset_rd", read_data, 0);
    chk("reset_ready", {31'd0, in_ready}, 1);
    chk("reset_stall", stall_cycles, 0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("vec%0d_hi", i), hi_value, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo_value, vecs[i].exp_lo);
      chk($sformatf("vec%0d_rv", i), {31'd0, read_valid}, {31'd0, vecs[i].exp_rv});
      chk($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, 1);
    end
    idle_inputs();
    step();
    chk("read_pulse_drop", {31'd0, read_valid}, 0);

    // Late divide: five stall cycles
    do_reset();
    start_div();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("div_wait%0d_ready", i), {31'd0, in_ready}, 0);
      step();
    end
    chk("div_wait4_ready", {31'd0, in_ready}, 0);
    divider_done = 1; divider_quotient = 7; divider_remainder = 3;
    step();
    idle_inputs();
    chk("div_done_ready", {31'd0, in_ready}, 1);
    chk("div_done_lo", lo_value, 7);
    chk("div_done_hi", hi_value, 3);
    chk("div_stall", stall_cycles, stall_exp(5));

    // Minimum stall: done the cycle after accept
    start_div();
    chk("min_ready_n1", {31'd0, in_ready}, 0);
    divider_done = 1; divider_quotient = 32'hA; divider_remainder = 32'hB;
    step();
    idle_inputs();
    chk("min_ready_n2", {31'd0, in_ready}, 1);
    chk("min_lo", lo_value, 32'hA);
    chk("min_hi", hi_value, 32'hB);
    chk("min_stall", stall_cycles, stall_exp(6));

    // Flush while waiting -> DRAIN, late done discarded
    start_div();
    step();
    flush = 1;
    step();
    flush = 0;
    chk("drain_ready", {31'd0, in_ready}, 0);
    flush = 1;
    step();
    flush = 0;
    chk("drain_flush_ignored", {31'd0, in_ready}, 0);
    divider_done = 1; divider_quotient = 9; divider_remainder = 4;
    step();
    idle_inputs();
    chk("drain_exit_ready", {31'd0, in_ready}, 1);
    chk("drain_lo", lo_value, 32'hA);
    chk("drain_hi", hi_value, 32'hB);

    // Done and flush together while waiting
    start_div();
    divider_done = 1; flush = 1; divider_quotient = 32'h12; divider_remainder = 32'h34;
    step();
    idle_inputs();
    chk("doneflush_ready", {31'd0, in_ready}, 1);
    chk("doneflush_lo", lo_value, 32'hA);
    chk("doneflush_hi", hi_value, 32'hB);

    // Asynchronous reset in the middle of a divide
    start_div();
    step();
    #2;
    reset_n = 0;
    #1;
    chk("areset_ready", {31'd0, in_ready}, 1);
    chk("areset_hi", hi_value, 0);
    chk("areset_lo", lo_value, 0);
    chk("areset_stall", stall_cycles, 0);
    step();
    reset_n = 1;
    divider_done = 1; divider_quotient = 32'h5; divider_remainder = 32'h6;
    step();
    idle_inputs();
    chk("areset_done_ignored_lo", lo_value, 0);
    chk("areset_done_ignored_hi", hi_value, 0);
    chk("areset_done_ready", {31'd0, in_ready}, 1);

    // Randomized traffic against the reference model
    do_reset();
    m_hi = 0; m_lo = 0; m_rd = 0; m_rv = 0; m_stall = 0; m_mode = 0;
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] kind;
      idle_inputs();
      kind = 4'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      high_low_write = kind inside {0, 1, 2, 3, 4};
      multiply_valid = (kind == 0);
      divide_valid = kind inside {1, 2};
      divide_result_valid = (kind == 1);
      result_high = (kind == 3 || kind == 5) || ($urandom_range(0, 7) == 0);
      result_low = (kind == 4 || kind == 6);
      multiply_result = {$urandom, $urandom};
      divide_result = $urandom; divide_remain = $urandom;
      source_register_data = $urandom;
      divider_done = ($urandom_range(0, 4) == 0);
      divider_quotient = $urandom; divider_remainder = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      model_clock();
      step();
      chk("rand_hi", hi_value, m_hi);
      chk("rand_lo", lo_value, m_lo);
      chk("rand_rv", {31'd0, read_valid}, {31'd0, m_rv});
      chk("rand_rd", read_data, m_rd);
      chk("rand_ready", {31'd0, in_ready}, {31'd0, (m_mode == 0)});
      chk("rand_stall", stall_cycles, stall_exp(m_stall));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_register_unit.md
# hilo_register_unit

Memory-stage (IO) consumer of the EX-to-IO multiply/divide fields: owns the architectural HI/LO registers and commits multiply products, divide quotient/remainder and MTHI/MTLO writes. It serves MFHI/MFLO reads and holds the pipeline, via a valid/ready handshake, while a sequential divide is still running. It sits between the EX-stage output register and the IO-stage result mux.

## Interface
- No parameters; data width is the core data width, 32 bits.
- clock  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX-to-IO bus entry valid
- in_ready  out  1  unit can accept an entry this cycle
- multiply_valid  in  1  entry is MULT/MULTU
- multiply_result  in  64  signed/unsigned product from the multiplier
- divide_valid  in  1  entry is DIV/DIVU
- divide_result_valid  in  1  quotient/remainder already valid at accept
- divide_result  in  32  quotient
- divide_remain  in  32  remainder
- source_register_data  in  32  rs value for MTHI/MTLO
- result_high  in  1  entry targets HI (MFHI/MTHI)
- result_low  in  1  entry targets LO (MFLO/MTLO)
- high_low_write  in  1  entry writes HI/LO
- divider_done  in  1  late divider completion pulse
- divider_quotient  in  32  quotient with divider_done
- divider_remainder  in  32  remainder with divider_done
- flush  in  1  cancel in-flight divide and any entry presented this cycle
- read_valid  out  1  MFHI/MFLO read data valid
- read_data  out  32  HI or LO value for MFHI/MFLO
- hi_value  out  32  current HI
- lo_value  out  32  current LO
- stall_cycles  out  32  divide stall counter (see Configuration)

## Operation
- Accept = in_valid & in_ready & !flush.
- States: IDLE, WAIT_DIVIDE, DRAIN. Reset -> IDLE.
- IDLE: in_ready=1. On accept:
  - multiply_valid & high_low_write: HI<=product[63:32], LO<=product[31:0].
  - divide_valid & high_low_write & divide_result_valid: LO<=divide_result, HI<=divide_remain; stay IDLE.
  - divide_valid & high_low_write & !divide_result_valid: -> WAIT_DIVIDE.
  - !multiply_valid & !divide_valid & high_low_write: result_high -> HI<=source_register_data; result_low -> LO<=source_register_data.
  - !high_low_write & (result_high|result_low): read; read_data<=HI if result_high else LO, read_valid<=1.
  - Other entries: accepted, no effect.
- divider_done in IDLE: ignored.
- WAIT_DIVIDE: in_ready=0. divider_done & !flush: LO<=divider_quotient, HI<=divider_remainder, -> IDLE. flush (with or without divider_done): no write; -> IDLE if divider_done same cycle, else -> DRAIN.
- DRAIN: in_ready=0; divider_done discarded, -> IDLE. flush ignored.
- Reset at any time, including mid-divide: state IDLE, HI=LO=0, read_valid=0, read_data=0, stall_cycles=0.

## Timing
- in_ready combinational from state only (no dependency on in_valid).
- HI/LO writes visible on hi_value/lo_value the cycle after the accept/done edge.
- Read latency 1: read_valid is a one-cycle pulse after accept; read_data holds until the next read.
- Read returns HI/LO as of the accept cycle; an immediately following read returns the previous entry's write (back-to-back write then read correct, no bubble).
- Minimum divide stall: accept in cycle N, divider_done in N+1, in_ready high in N+2.

## Configuration
- HILO_STALL_COUNTER_EN defined: stall_cycles increments (wrapping at 2^32) every cycle state != IDLE; cleared only by reset.
- Undefined: counter logic absent; stall_cycles tied to 0.

## Test plan
- Reset then MULT accept with product 0x00000001_FFFFFFFE -> next cycle hi_value=0x1, lo_value=0xFFFFFFFE; MFHI next entry -> read_valid pulse, read_data=0x1.
- DIV accept, divide_result_valid=0; divider_done after 5 cycles with quotient 7, remainder 3 -> in_ready low 5 cycles, then LO=7, HI=3; stall_cycles=5 with macro, 0 without.
- MTLO 0xDEADBEEF then MFLO back-to-back -> LO=0xDEADBEEF, read_data=0xDEADBEEF one cycle after second accept.
- DIV pending, flush two cycles later, divider_done later with quotient 9 -> DRAIN entered, HI/LO unchanged, in_ready high cycle after done.
- flush with in_valid in IDLE for MTHI 0x55 -> HI unchanged; divider_done+flush same cycle in WAIT_DIVIDE -> no write, IDLE next.
- reset_n asserted mid WAIT_DIVIDE -> immediately IDLE, HI=LO=0, in_ready=1, later divider_done ignored.
